// File: rtl/pcre_engine_pkg.sv
// Shared definitions for the PCRE chain engines: default widths and
// elaboration-time parameter sanity helpers.
package pcre_engine_pkg;

    localparam int DEF_OFF_W = 16;
    localparam int DEF_CNT_W = 8;

    function automatic int cls_width(input int n_class);
        int w;
        w = 1;
        while ((2 ** w) < n_class) w++;
        return w;
    endfunction

    // Last position may not be a `*` position: a hit must consume a byte there.
    function automatic bit params_ok(input int n_states, input int n_class,
                                     input int cls_w, input logic [63:0] loop_mask);
        if (n_states < 2 || n_states > 64) return 1'b0;
        if (loop_mask[n_states-1]) return 1'b0;
        if ((2 ** cls_w) < n_class) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/pcre_nfa_cell.sv
// One position of the linear regex chain: a single active flop, optionally
// self-looping for `*` positions.
module pcre_nfa_cell (
    input  logic clk,
    input  logic sod,
    input  logic en,
    input  logic e,
    input  logic cls,
    input  logic loop,
    output logic a,
    output logic d
);

    logic a_q;

    always_comb begin
        d = cls & (e | (loop & a_q));
    end

    always_ff @(posedge clk) begin
        if (sod) begin
            a_q <= 1'b0;
        end else if (en) begin
            a_q <= d;
        end
    end

    assign a = a_q;

endmodule

// File: rtl/pcre_chain_engine.sv
// Linear regex chain matcher over the decoded class bus, with sticky match,
// hit pulse, saturating hit count and first-hit offset capture.
module pcre_chain_engine
    import pcre_engine_pkg::*;
#(
    parameter int                        N_CLASS   = 128,
    parameter int                        CLS_W     = cls_width(N_CLASS),
    parameter int                        N_STATES  = 12,
    parameter logic [N_STATES*CLS_W-1:0] CLS_SEL   = '0,
    parameter logic [N_STATES-1:0]       LOOP_MASK = '0,
    parameter bit                        ANCHORED  = 1'b0,
    parameter int                        OFF_W     = DEF_OFF_W,
    parameter int                        CNT_W     = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               sod,
    input  logic               en,
    input  logic [N_CLASS-1:0] cls_in,
    output logic               match,
    output logic               match_pulse,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               first_valid,
    output logic [OFF_W-1:0]   first_off,
    output logic [OFF_W-1:0]   byte_off
);

    if (!params_ok(N_STATES, N_CLASS, CLS_W, 64'(LOOP_MASK))) begin : g_bad_params
        $error("pcre_chain_engine: bad N_STATES/LOOP_MASK/CLS_W combination");
    end

    logic [N_STATES-1:0] a_vec;
    logic [N_STATES-1:0] d_vec;
    logic [N_STATES-1:0] e_vec;
    logic                s_tok;
    logic                hit;

    logic               start_q, start_d;
    logic               match_q, match_d;
    logic               pulse_q, pulse_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               first_valid_q, first_valid_d;
    logic [OFF_W-1:0]   first_off_q, first_off_d;
    logic [OFF_W-1:0]   byte_off_q, byte_off_d;

    assign s_tok = ANCHORED ? start_q : 1'b1;

    // Runs of `*` positions are bypassed recursively by chaining enables.
    always_comb begin
        e_vec    = '0;
        e_vec[0] = s_tok;
        for (int i = 1; i < N_STATES; i++) begin
            e_vec[i] = a_vec[i-1] | (LOOP_MASK[i-1] & e_vec[i-1]);
        end
    end

    for (genvar i = 0; i < N_STATES; i++) begin : g_cell
        pcre_nfa_cell u_cell (
            .clk  (clk),
            .sod  (sod),
            .en   (en),
            .e    (e_vec[i]),
            .cls  (cls_in[CLS_SEL[i*CLS_W +: CLS_W]]),
            .loop (LOOP_MASK[i]),
            .a    (a_vec[i]),
            .d    (d_vec[i])
        );
    end

    assign hit = en & d_vec[N_STATES-1];

    always_comb begin
        start_d       = start_q;
        match_d       = match_q;
        pulse_d       = hit;
        cnt_d         = cnt_q;
        first_valid_d = first_valid_q;
        first_off_d   = first_off_q;
        byte_off_d    = byte_off_q;
        if (en) begin
            start_d    = 1'b0;
            byte_off_d = (&byte_off_q) ? byte_off_q : byte_off_q + OFF_W'(1);
        end
        if (hit) begin
            match_d = 1'b1;
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            if (!first_valid_q) begin
                first_valid_d = 1'b1;
                first_off_d   = byte_off_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sod) begin
            start_q       <= 1'b1;
            match_q       <= 1'b0;
            pulse_q       <= 1'b0;
            cnt_q         <= '0;
            first_valid_q <= 1'b0;
            first_off_q   <= '0;
            byte_off_q    <= '0;
        end else begin
            start_q       <= start_d;
            match_q       <= match_d;
            pulse_q       <= pulse_d;
            cnt_q         <= cnt_d;
            first_valid_q <= first_valid_d;
            first_off_q   <= first_off_d;
            byte_off_q    <= byte_off_d;
        end
    end

    assign match       = match_q;
    assign match_pulse = pulse_q;
    assign match_cnt   = cnt_q;
    assign first_valid = first_valid_q;
    assign first_off   = first_off_q;
    assign byte_off    = byte_off_q;

endmodule
